// File: rtl/contador_pkg.sv
// Shared definitions for monitor_contador: FSM encoding, step constants,
// event bundle and the hex 7-segment table ({g..a}, active high).
package contador_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned CONS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DELTA_UP = 4'h1;
  localparam logic [CNT_W-1:0] DELTA_DN = 4'hF;

  typedef struct packed {
    logic up;
    logic down;
    logic hold;
    logic wrap;
    logic err;
  } evt_t;

  // Index 15 first, index 0 last.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/decod_7seg.sv
// Combinational hex to 7-segment decoder ({g..a}, active high).
module decod_7seg
  import contador_pkg::*;
(
  input  logic [CNT_W-1:0] hex,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup of the current nibble.
  assign seg_c = SEG_TABLE[hex];

endmodule

// File: rtl/monitor_contador.sv
// Monitors a hex counter and classifies every step as up/down/hold/wrap/error.
// Optional macro SEG7_EN adds a registered 7-segment display of the last sample.
module monitor_contador
  import contador_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] q_in,
  input  logic             sync,
  input  logic             clr,
  output logic             evt_up,
  output logic             evt_down,
  output logic             evt_hold,
  output logic             evt_wrap,
  output logic             evt_err,
  output logic             dir_out,
  output logic             fault,
  output logic [ERR_W-1:0] err_cnt,
  output logic [SEG_W-1:0] seg
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    prev;
  logic [CNT_W-1:0]    delta;
  logic [CONS_W-1:0]   cons_q, cons_d, cons_inc;
  logic [ERR_W-1:0]    err_d;
  logic                dir_d;
  evt_t                evt_q, evt_d;

  assign delta    = q_in - prev;
  assign cons_inc = cons_q + 4'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, step classification and next values of the output registers.
  always_comb begin
    state_d = state_q;
    evt_d   = '0;
    cons_d  = cons_q;
    err_d   = err_cnt;
    dir_d   = dir_out;
    if (clr) begin
      state_d = IDLE;
      cons_d  = '0;
      err_d   = '0;
    end else if (sync) begin
      state_d = IDLE;
      cons_d  = '0;
    end else begin
      unique case (state_q)
        IDLE:  state_d = TRACK;
        TRACK: begin
          if (delta == 4'h0) begin
            evt_d.hold = 1'b1;
          end else if (prev == 4'h0 && q_in == 4'hF) begin
            evt_d.wrap = 1'b1;
            evt_d.down = 1'b1;
            dir_d      = 1'b1;
          end else if (delta == DELTA_UP && prev != 4'hF) begin
            evt_d.up = 1'b1;
            dir_d    = 1'b0;
          end else if (delta == DELTA_DN) begin
            evt_d.down = 1'b1;
            dir_d      = 1'b1;
          end else begin
            evt_d.err = 1'b1;
          end
          if (evt_d.err) begin
            if (err_cnt != 8'hFF) err_d = err_cnt + 8'd1;
            cons_d = cons_inc;
            if (cons_inc >= 4'(ERR_LIMIT)) state_d = FAULT;
          end else begin
            cons_d = '0;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath registers; prev follows q_in in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      cons_q  <= '0;
      err_cnt <= '0;
      dir_out <= 1'b0;
      fault   <= 1'b0;
      evt_q   <= '0;
    end else begin
      prev    <= q_in;
      cons_q  <= cons_d;
      err_cnt <= err_d;
      dir_out <= dir_d;
      fault   <= (state_d == FAULT);
      evt_q   <= evt_d;
    end
  end

  assign evt_up   = evt_q.up;
  assign evt_down = evt_q.down;
  assign evt_hold = evt_q.hold;
  assign evt_wrap = evt_q.wrap;
  assign evt_err  = evt_q.err;

`ifdef SEG7_EN
  logic [SEG_W-1:0] seg_c;

  decod_7seg u_decod_7seg (
    .hex   (prev),
    .seg_c (seg_c)
  );

  // Display register, one cycle behind prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg <= '0;
    else        seg <= seg_c;
  end
`else
  assign seg = 7'b0000000;
`endif

endmodule

// File: tb/tb_monitor_contador.sv
// Scoreboard bench for monitor_contador (build with or without SEG7_EN).
module tb_monitor_contador;

  localparam int unsigned LIMIT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] q_in = 4'h0;
  logic       sync = 1'b0;
  logic       clr = 1'b0;
  logic       evt_up, evt_down, evt_hold, evt_wrap, evt_err;
  logic       dir_out, fault;
  logic [7:0] err_cnt;
  logic [6:0] seg;

  monitor_contador #(.ERR_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .q_in     (q_in),
    .sync     (sync),
    .clr      (clr),
    .evt_up   (evt_up),
    .evt_down (evt_down),
    .evt_hold (evt_hold),
    .evt_wrap (evt_wrap),
    .evt_err  (evt_err),
    .dir_out  (dir_out),
    .fault    (fault),
    .err_cnt  (err_cnt),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] evt;   // {up, down, hold, wrap, err}
    logic       dir;
    logic       flt;
    logic [7:0] err;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 0 idle, 1 track, 2 fault.
  int         m_state;
  int         m_prev;
  int         m_cons;
  int         m_err;
  logic       m_dir;

  // Pulses seen on the DUT since the last tally clear.
  int t_up, t_down, t_hold, t_wrap, t_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      10: return 7'b1110111; 11: return 7'b1111100;
      12: return 7'b0111001; 13: return 7'b1011110;
      14: return 7'b1111001; default: return 7'b1110001;
    endcase
  endfunction

  task automatic clear_tally();
    t_up = 0; t_down = 0; t_hold = 0; t_wrap = 0; t_err = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_evt"}, 32'({evt_up, evt_down, evt_hold, evt_wrap, evt_err}), 32'd0);
    check_eq({tag, "_dir"}, 32'(dir_out), 32'd0);
    check_eq({tag, "_fault"}, 32'(fault), 32'd0);
    check_eq({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    check_eq({tag, "_seg"}, 32'(seg), 32'd0);
  endtask

  // Assert reset now, check outputs, release just before the next drive point.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    m_state = 0; m_prev = 0; m_cons = 0; m_err = 0; m_dir = 1'b0;
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Drive one sample, predict the registered result, then compare after the edge.
  task automatic step(input int q, input logic s = 1'b0, input logic c = 1'b0);
    exp_t e;
    exp_t g;
    int   d;
    @(negedge clk);
    q_in = 4'(q); sync = s; clr = c;
    e.evt = 5'b0;
`ifdef SEG7_EN
    e.seg = seg_ref(m_prev);
`else
    e.seg = 7'b0;
`endif
    if (c) begin
      m_state = 0; m_err = 0; m_cons = 0;
    end else if (s) begin
      m_state = 0; m_cons = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      d = (q + 16 - m_prev) % 16;
      if (d == 0)                          e.evt = 5'b00100;
      else if (m_prev == 0 && q == 15)     begin e.evt = 5'b01010; m_dir = 1'b1; end
      else if (d == 1 && m_prev != 15)     begin e.evt = 5'b10000; m_dir = 1'b0; end
      else if (d == 15)                    begin e.evt = 5'b01000; m_dir = 1'b1; end
      else                                 e.evt = 5'b00001;
      if (e.evt[0]) begin
        m_err  = (m_err < 255) ? m_err + 1 : 255;
        m_cons = m_cons + 1;
        if (m_cons >= int'(LIMIT)) m_state = 2;
      end else begin
        m_cons = 0;
      end
    end
    e.dir = m_dir;
    e.flt = (m_state == 2);
    e.err = 8'(m_err);
    m_prev = q;
    sb.push_back(e);

    @(posedge clk);
    #1;
    sync = 1'b0; clr = 1'b0;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check_eq("evt", 32'({evt_up, evt_down, evt_hold, evt_wrap, evt_err}), 32'(g.evt));
      check_eq("dir", 32'(dir_out), 32'(g.dir));
      check_eq("fault", 32'(fault), 32'(g.flt));
      check_eq("errcnt", 32'(err_cnt), 32'(g.err));
      check_eq("seg", 32'(seg), 32'(g.seg));
    end
    t_up   += int'(evt_up);
    t_down += int'(evt_down);
    t_hold += int'(evt_hold);
    t_wrap += int'(evt_wrap);
    t_err  += int'(evt_err);
  endtask

  initial begin
    logic [6:0] seg_a;
    @(posedge clk);
    do_reset("reset");

    // Up-count run followed by holds.
    clear_tally();
    step(0);
    for (int i = 1; i < 16; i++) step(i);
    step(15);
    step(15);
    check_eq("up_run_ups", 32'(t_up), 32'd15);
    check_eq("up_run_holds", 32'(t_hold), 32'd2);
    check_eq("up_run_errs", 32'(t_err), 32'd0);
    check_eq("up_run_dir", 32'(dir_out), 32'd0);

    // Down-count run through the 0->F wrap.
    step(2, 1'b1);
    clear_tally();
    step(2);
    step(1); step(0); step(15); step(14);
    check_eq("dn_run_downs", 32'(t_down), 32'd4);
    check_eq("dn_run_wraps", 32'(t_wrap), 32'd1);
    check_eq("dn_run_dir", 32'(dir_out), 32'd1);

    // F->0 is illegal; block stays in TRACK.
    clear_tally();
    step(15);
    step(0);
    check_eq("f0_err_pulse", 32'(evt_err), 32'd1);
    check_eq("f0_errcnt", 32'(err_cnt), 32'd1);
    check_eq("f0_fault", 32'(fault), 32'd0);
    step(1);
    check_eq("f0_still_track", 32'(evt_up), 32'd1);

    // Consecutive errors reach the limit, FAULT freezes, clr recovers.
    step(0, 1'b1);
    clear_tally();
    step(0); step(5); step(10);
    check_eq("lim_no_fault_yet", 32'(fault), 32'd0);
    step(3);
    check_eq("lim_fault_with_err", 32'({fault, evt_err}), 32'b11);
    check_eq("lim_errs", 32'(t_err), 32'd3);
    clear_tally();
    step(9); step(2); step(2);
    check_eq("fault_silent", 32'(t_up + t_down + t_hold + t_wrap + t_err), 32'd0);
    check_eq("fault_errcnt_frozen", 32'(err_cnt), 32'd4);
    step(2, 1'b0, 1'b1);
    check_eq("clr_fault", 32'(fault), 32'd0);
    check_eq("clr_errcnt", 32'(err_cnt), 32'd0);
    step(2);
    step(3);
    check_eq("clr_back_to_track", 32'(evt_up), 32'd1);

    // err_cnt saturation: two errors then a hold keeps clear of the limit.
    for (int i = 0; i < 130; i++) begin
      step(11); step(3); step(3);
    end
    check_eq("errcnt_sat", 32'(err_cnt), 32'd255);
    check_eq("sat_no_fault", 32'(fault), 32'd0);

    // Async reset while tracking 7, then restart without a spurious error.
    step(7);
    step(7);
    #1;
    do_reset("mid_reset");
    clear_tally();
    step(7);
    step(8);
    check_eq("post_rst_errs", 32'(t_err), 32'd0);
    check_eq("post_rst_ups", 32'(t_up), 32'd1);

    // Display follows a held value two samples later.
    step(10);
    step(10);
`ifdef SEG7_EN
    seg_a = 7'b1110111;
`else
    seg_a = 7'b0000000;
`endif
    check_eq("seg_hex_a", 32'(seg), 32'(seg_a));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/monitor_contador.md
MONITOR_CONTADOR -- requirements
Module: monitor_contador

Interface
REQ-001 Parameter ERR_LIMIT, default 3, SHALL set the number of consecutive illegal transitions that forces FAULT (legal range 1..15).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 q_in  in  4  SHALL carry the observed hex count (0..F) from a counter clocked by the same clk.
REQ-005 sync  in  1  SHALL, when high, force the block to IDLE (resynchronise without reset).
REQ-006 clr  in  1  SHALL, when high, clear err_cnt and leave FAULT.
REQ-007 evt_up, evt_down, evt_hold, evt_wrap, evt_err  out  1 each  SHALL be one-cycle event pulses.
REQ-008 dir_out  out  1  SHALL hold the last inferred direction (0 incremental, 1 decremental).
REQ-009 fault  out  1  SHALL be high while in FAULT.
REQ-010 err_cnt  out  8  SHALL count illegal transitions.
REQ-011 seg  out  7  SHALL drive a 7-segment pattern {g..a}, active high.

Function
REQ-012 The block SHALL register q_in every cycle as prev; classification SHALL compare q_in with prev, delta = (q_in - prev) mod 16.
REQ-013 States SHALL be IDLE, TRACK and FAULT.
REQ-014 IDLE SHALL capture q_in into prev, assert no event and move to TRACK on the next cycle.
REQ-015 In TRACK: delta 0 -> evt_hold; delta 1 with prev != F -> evt_up, dir_out=0; delta F with prev != 0 -> evt_down, dir_out=1; prev=0 and q_in=F -> evt_wrap and evt_down, dir_out=1.
REQ-016 Every other TRACK transition, including F->0, SHALL assert evt_err and leave dir_out unchanged.
REQ-017 Event outputs SHALL be registered, asserted exactly in the cycle after the transition is sampled (latency 1), and mutually exclusive except wrap+down.
REQ-018 A consecutive-error counter SHALL increment on each evt_err and clear on any legal event; reaching ERR_LIMIT SHALL move TRACK to FAULT in the same cycle evt_err is pulsed.
REQ-019 err_cnt SHALL saturate at 255 (no wrap).
REQ-020 In FAULT: no events, err_cnt frozen, prev keeps tracking q_in; exit only via clr or sync, both to IDLE.
REQ-021 Priority SHALL be rst_n > clr > sync > normal operation; clr also implies the sync behaviour.
REQ-022 sync SHALL clear the consecutive-error counter but not err_cnt.

Reset
REQ-023 On rst_n low: state IDLE, prev 0, all evt_* 0, dir_out 0, fault 0, err_cnt 0, consecutive counter 0, seg 0.
REQ-024 Reset deassertion mid-stream SHALL restart in IDLE; the first post-reset sample SHALL never produce evt_err.

Configuration
REQ-025 With SEG7_EN defined, seg SHALL be the registered 7-segment decode of prev (hex 0..F, e.g. 0 -> 0111111, F -> 1110001), updated one cycle after prev.
REQ-026 Without SEG7_EN, seg SHALL be tied to 7'b0000000 and no decode logic instantiated.

Structure
REQ-027 A shared package contador_pkg SHALL hold the state encoding (IDLE/TRACK/FAULT), the delta constants (DELTA_UP=1, DELTA_DN=4'hF) and the 16-entry 7-segment table.
REQ-028 The 7-segment decode SHALL be a sub-module decod_7seg (4-bit in, 7-bit out, combinational), instantiated only under SEG7_EN.

Verification
REQ-029 Reset, q_in 0,1,2,...,F,F,F -> after IDLE cycle, 15 evt_up pulses then evt_hold twice, dir_out 0, err_cnt 0.
REQ-030 q_in 2,1,0,F,E -> evt_down x4, evt_wrap with the 0->F step only, dir_out 1.
REQ-031 q_in F then 0 in TRACK -> evt_err, err_cnt 1, state TRACK.
REQ-032 ERR_LIMIT=3, q_in 0,5,A,3 -> three evt_err, fault high on third; further jumps give no events; clr -> fault 0, err_cnt 0, IDLE then TRACK.
REQ-033 rst_n pulsed low while q_in=7 in TRACK -> all outputs zero immediately; after release, q_in 7 then 8 -> no evt_err, one evt_up.
REQ-034 With SEG7_EN, q_in held at A -> seg = 1110111 two cycles later; without SEG7_EN seg stays 0.
